regfile_read_arbiter: RTL and testbench
=======================================

// Module: regfile_read_arbiter
// PURPOSE
//  Shares the single LC-3 register-file read port (8:1 x16 read mux) among
//  NUM_REQ requesters (e.g. decode, address gen, debug). Round-robin grant
//  each cycle drives the mux select; the selected register value is captured
//  and returned to the winner one cycle later, tagged with its requester ID.
// PARAMETERS
//  NUM_REQ  4   number of requesters, legal 2..8
//  DATA_W   16  register width
//  ADDR_W   3   register index width (8 registers)
//  ID_W     2   requester ID width, must equal clog2(NUM_REQ)
// PORTS
//  clk         in   1               rising-edge clock
//  reset_n     in   1               async active-low reset
//  req         in   NUM_REQ         request per requester, held until granted
//  req_addr    in   NUM_REQ*ADDR_W  requester i index at [i*ADDR_W +: ADDR_W]
//  stall       in   1               blocks all grants this cycle
//  gnt         out  NUM_REQ         one-hot grant, combinational, same cycle
//  rd_sel      out  ADDR_W          register-file read mux select
//  rd_data     in   DATA_W          register-file read mux output
//  wr_en       in   1               register-file write strobe (this cycle)
//  wr_addr     in   ADDR_W          register-file write index
//  wr_data     in   DATA_W          register-file write data
//  resp_valid  out  1               response valid (1-cycle pulse per grant)
//  resp_id     out  ID_W            ID of the requester being answered
//  resp_data   out  DATA_W          register value returned
// BEHAVIOUR
//  - Single clock domain; reset_n low asynchronously forces: resp_valid=0,
//    resp_id=0, resp_data=0, rr pointer ptr=0. gnt=0 and rd_sel=0 while
//    reset_n low. Reset mid-operation drops any in-flight response.
//  - Arbitration (comb): if stall=0 and |req, grant first set req scanning
//    ptr, ptr+1, ... wrapping modulo NUM_REQ. At most one gnt bit high.
//  - No grant (stall=1 or req=0): gnt=0, rd_sel=0, ptr unchanged.
//  - rd_sel = req_addr of granted requester, same cycle as gnt.
//  - On grant to i at edge: ptr <= (i+1) mod NUM_REQ (NUM_REQ-1 wraps to 0);
//    resp_valid<=1, resp_id<=i, resp_data<=captured value. Latency 1 cycle.
//  - Cycle without grant: resp_valid<=0; resp_id/resp_data hold last value.
//  - Back-to-back grants allowed every cycle; full throughput 1 read/cycle.
//  - Requester sees gnt and deasserts/changes req next cycle; req held high
//    after grant is treated as a new request.
//  - Bits of req_addr for non-granted requesters are don't-care.
//  - Register-file write occurs at the same edge; rd_data shows pre-write
//    value during the grant cycle (see CONFIGURATION).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: if wr_en=1 and wr_addr==rd_sel in the grant
//    cycle, resp_data<=wr_data (write-to-read forwarding), else rd_data.
//  REGFILE_BYPASS_EN undefined: resp_data<=rd_data always; wr_en/wr_addr/
//    wr_data ports present but ignored.
// TESTING
//  1 reset_n=0 while resp_valid=1 -> resp_valid=0, resp_data=0, resp_id=0
//    immediately (no clock); after release first grant starts at req 0.
//  2 req=4'b0001, addr0=3'd5, rd_data=16'hBEEF -> gnt=0001, rd_sel=5 same
//    cycle; next cycle resp_valid=1, resp_id=0, resp_data=16'hBEEF.
//  3 req=4'b1111 held 5 cycles -> gnt 0001,0010,0100,1000,0001; resp_id
//    0,1,2,3,0 one cycle later each; resp_valid continuously 1.
//  4 ptr=3 (after grant to 2), req=4'b0011 -> gnt=0001 (wrap), ptr->1;
//    next cycle req=4'b0011 -> gnt=0010.
//  5 req=4'b1111, stall=1 two cycles -> gnt=0, rd_sel=0, resp_valid=0 after
//    one cycle, ptr unchanged; stall=0 resumes at held ptr.
//  6 grant addr 2, rd_data=16'h0000, wr_en=1, wr_addr=2, wr_data=16'h1234 ->
//    resp_data=16'h1234 with REGFILE_BYPASS_EN, 16'h0000 without.

Source files
------------

// File: rtl/regfile_read_arbiter_if.sv
// Bus bundle for the register-file read arbiter: requester side, register-file
// read/write taps and the tagged response channel.
interface regfile_read_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic                      stall;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rd_sel;
  logic [DATA_W-1:0]         rd_data;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      resp_valid;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_data;

  // Environment side: requesters plus the register file itself
  modport master (
    output req, req_addr, stall, rd_data, wr_en, wr_addr, wr_data,
    input  gnt, rd_sel, resp_valid, resp_id, resp_data
  );

  // Arbiter side
  modport slave (
    input  req, req_addr, stall, rd_data, wr_en, wr_addr, wr_data,
    output gnt, rd_sel, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing the single LC-3 register-file read port among
// NUM_REQ requesters. Grant and mux select are combinational; the selected
// value is registered and returned one cycle later tagged with the winner ID.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle register
// write into the captured response (write-to-read forwarding).
module regfile_read_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned ID_W    = 2
) (
  input logic                    clk,
  input logic                    reset_n,
  regfile_read_arbiter_if.slave  bus
);

  logic [ID_W-1:0]    r_ptr;
  logic               r_resp_valid;
  logic [ID_W-1:0]    r_resp_id;
  logic [DATA_W-1:0]  r_resp_data;

  logic [NUM_REQ-1:0] w_gnt;
  logic               w_grant;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_cand;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [ADDR_W-1:0]  w_rd_sel;
  logic [DATA_W-1:0]  w_cap;

  // Round-robin scan from r_ptr; grant is suppressed while in reset or stalled
  always_comb begin
    w_gnt   = '0;
    w_grant = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    if (reset_n && !bus.stall) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_cand = ID_W'((32'(r_ptr) + k) % NUM_REQ);
        if (!w_grant && bus.req[w_cand]) begin
          w_grant = 1'b1;
          w_idx   = w_cand;
        end
      end
    end
    if (w_grant) begin
      w_gnt[w_idx] = 1'b1;
    end
  end

  // Read-mux select and next pointer for the current winner
  always_comb begin
    w_rd_sel  = '0;
    w_ptr_nxt = r_ptr;
    if (w_grant) begin
      w_rd_sel  = bus.req_addr[w_idx*ADDR_W +: ADDR_W];
      w_ptr_nxt = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Value to capture: forward a write landing on the selected register
  always_comb begin
    w_cap = bus.rd_data;
    if (bus.wr_en && (bus.wr_addr == w_rd_sel)) begin
      w_cap = bus.wr_data;
    end
  end
`else
  logic w_unused_wr;

  // Value to capture: read-mux output as is; write taps are not consulted
  always_comb begin
    w_cap       = bus.rd_data;
    w_unused_wr = ^{bus.wr_en, bus.wr_addr, bus.wr_data};
  end
`endif

  // Pointer advance and one-cycle response register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
    end else if (w_grant) begin
      r_ptr        <= w_ptr_nxt;
      r_resp_valid <= 1'b1;
      r_resp_id    <= w_idx;
      r_resp_data  <= w_cap;
    end else begin
      r_resp_valid <= 1'b0;
    end
  end

  assign bus.gnt        = w_gnt;
  assign bus.rd_sel     = w_rd_sel;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_data  = r_resp_data;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter: directed scenarios with literal
// expectations followed by randomized traffic compared every cycle against a
// behavioural round-robin model and a register-file array.
module tb_regfile_read_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  regfile_read_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) bus ();

  regfile_read_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Register file model: combinational read, write at the clock edge
  logic [DW-1:0] regs [8];
  always_comb bus.rd_data = regs[bus.rd_sel];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner under the round-robin rule, -1 when nothing is granted
  function automatic int pick(input logic [N-1:0] rq, input logic st, input int p);
    if (st) return -1;
    for (int k = 0; k < N; k++) begin
      if (rq[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  int            m_ptr;
  logic          m_valid;
  logic [IW-1:0] m_id;
  logic [DW-1:0] m_data;

  // Reference model state update
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ptr   = 0;
      m_valid = 1'b0;
      m_id    = '0;
      m_data  = '0;
    end else begin
      int g;
      logic [AW-1:0] a;
      g = pick(bus.req, bus.stall, m_ptr);
      if (g >= 0) begin
        a      = bus.req_addr[g*AW +: AW];
        m_data = regs[a];
`ifdef REGFILE_BYPASS_EN
        if (bus.wr_en && bus.wr_addr == a) m_data = bus.wr_data;
`endif
        m_valid = 1'b1;
        m_id    = IW'(g);
        m_ptr   = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
      if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (reset_n) begin
      int g;
      logic [N-1:0]  eg;
      logic [AW-1:0] es;
      g  = pick(bus.req, bus.stall, m_ptr);
      eg = '0;
      es = '0;
      if (g >= 0) begin
        eg[g] = 1'b1;
        es    = bus.req_addr[g*AW +: AW];
      end
      check("gnt",        32'(bus.gnt),        32'(eg));
      check("rd_sel",     32'(bus.rd_sel),     32'(es));
      check("resp_valid", 32'(bus.resp_valid), 32'(m_valid));
      check("resp_id",    32'(bus.resp_id),    32'(m_id));
      check("resp_data",  32'(bus.resp_data),  32'(m_data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.stall    = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    for (int i = 0; i < 8; i++) regs[i] <= DW'($urandom);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    @(negedge clk);
    check("rst_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_data",  32'(bus.resp_data),  32'd0);

    // Single requester, value returned one cycle later
    step();
    bus.req      = 4'b0001;
    bus.req_addr = 12'(3'd5);
    regs[5]     <= 16'hBEEF;
    @(negedge clk);
    check("t2_gnt",    32'(bus.gnt),    32'h1);
    check("t2_rd_sel", 32'(bus.rd_sel), 32'd5);
    step();
    bus.req = '0;
    @(negedge clk);
    check("t2_valid", 32'(bus.resp_valid), 32'd1);
    check("t2_id",    32'(bus.resp_id),    32'd0);
    check("t2_data",  32'(bus.resp_data),  32'hBEEF);

    // Asynchronous reset while a response is valid
    #2 reset_n = 1'b0;
    #1;
    check("t1_valid", 32'(bus.resp_valid), 32'd0);
    check("t1_id",    32'(bus.resp_id),    32'd0);
    check("t1_data",  32'(bus.resp_data),  32'd0);
    check("t1_gnt",   32'(bus.gnt),        32'd0);
    step();
    reset_n = 1'b1;

    // All requesting: rotation starts at requester 0
    step();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_gnt", 32'(bus.gnt), 32'(1 << (k % 4)));
      if (k > 0) begin
        check("t3_valid", 32'(bus.resp_valid), 32'd1);
        check("t3_id",    32'(bus.resp_id),    32'((k - 1) % 4));
      end
      step();
    end
    bus.req = '0;
    @(negedge clk);
    check("t3_last_id", 32'(bus.resp_id), 32'd0);

    // Pointer wrap from 3 back to 0
    step();
    bus.req = 4'b0100;
    @(negedge clk);
    check("t4_gnt2", 32'(bus.gnt), 32'h4);
    step();
    bus.req = 4'b0011;
    @(negedge clk);
    check("t4_wrap", 32'(bus.gnt), 32'h1);
    step();
    @(negedge clk);
    check("t4_next", 32'(bus.gnt), 32'h2);
    step();
    bus.req = '0;

    // Stall holds the pointer
    bus.req   = 4'b1111;
    bus.stall = 1'b1;
    @(negedge clk);
    check("t5_gnt",    32'(bus.gnt),    32'd0);
    check("t5_rd_sel", 32'(bus.rd_sel), 32'd0);
    step();
    @(negedge clk);
    check("t5_gnt2",  32'(bus.gnt),        32'd0);
    check("t5_valid", 32'(bus.resp_valid), 32'd0);
    step();
    bus.stall = 1'b0;
    @(negedge clk);
    check("t5_resume", 32'(bus.gnt), 32'h4);
    step();
    bus.req = '0;

    // Same-cycle write to the register being read
    bus.req      = 4'b0001;
    bus.req_addr = 12'(3'd2);
    regs[2]     <= 16'h0000;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 3'd2;
    bus.wr_data  = 16'h1234;
    @(negedge clk);
    check("t6_gnt", 32'(bus.gnt), 32'h1);
    step();
    bus.wr_en = 1'b0;
    bus.req   = '0;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    check("t6_data", 32'(bus.resp_data), 32'h1234);
`else
    check("t6_data", 32'(bus.resp_data), 32'h0000);
`endif

    // Randomized traffic with one mid-run reset
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c == 1500) reset_n = 1'b0;
      if (c == 1503) reset_n = 1'b1;
      bus.req      = N'($urandom);
      bus.req_addr = (N*AW)'($urandom);
      bus.stall    = ($urandom_range(0, 7) == 0);
      bus.wr_en    = 1'($urandom_range(0, 1));
      bus.wr_addr  = AW'($urandom);
      bus.wr_data  = DW'($urandom);
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
